// File: rtl/branch_pkg.sv
// Shared types for the branch resolution unit.
// Optional return-address stack is enabled by defining BRANCH_RAS_EN.
package branch_pkg;

  localparam logic [1:0] BR_CLASS = 2'b10;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_JMP  = 3'd4,
    BR_CALL = 3'd5,
    BR_RET  = 3'd6,
    BR_RSVD = 3'd7
  } br_cond_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when BRANCH_RAS_EN is defined.
module branch_ras
  import branch_pkg::*;
#(
  parameter int PC_W      = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [PW-1:0]   w_top_idx;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(RAS_DEPTH));
  assign overflow  = r_ovf;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

  // r_ptr is the next free slot; when full it also marks the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= push && full;
      if (push) begin
        r_ptr <= r_ptr + PW'(1);
        if (!full) r_count <= r_count + CW'(1);
      end else if (pop && !empty) begin
        r_ptr   <= r_ptr - PW'(1);
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: flags, condition evaluation, redirect handshake.
// Define BRANCH_RAS_EN to build the return-address stack for CALL/RET.
module branch_unit
  import branch_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int PC_W      = 11,
  parameter int DATA_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               alu_valid,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               is_branch,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  input  logic               redirect_ready,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  br_state_e       r_state;
  br_state_e       w_state_nxt;
  logic            r_z;
  logic            r_n;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_unf;

  br_cond_e        w_cond;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_tgt_pc;
  logic            w_accept;
  logic            w_taken;
  logic            w_is_ret;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;

  assign w_cond      = br_cond_e'(instr[4:2]);
  assign w_target    = instr[5 +: PC_W];
  assign is_branch   = (instr[1:0] == BR_CLASS);
  assign instr_ready = (r_state == IDLE);
  assign w_accept    = instr_valid && instr_ready && is_branch;
  assign w_is_ret    = (w_cond == BR_RET);

`ifdef BRANCH_RAS_EN
  logic w_push;
  logic w_pop;
  logic w_unused_full;

  assign w_push = w_accept && (w_cond == BR_CALL);
  assign w_pop  = w_accept && w_is_ret && !w_ras_empty;

  branch_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_in + PC_W'(1)),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_unused_full),
    .overflow  (ras_overflow)
  );
`else
  logic w_unused_pc;

  assign w_ras_top    = '0;
  assign w_ras_empty  = 1'b1;
  assign ras_overflow = 1'b0;
  assign w_unused_pc  = ^pc_in;
`endif

  // Empty RAS (or no RAS) turns RET into a not-taken underflow
  always_comb begin
    w_taken = 1'b0;
    unique case (w_cond)
      BR_BEQ:  w_taken = r_z;
      BR_BNE:  w_taken = !r_z;
      BR_BLT:  w_taken = r_n;
      BR_BGE:  w_taken = !r_n;
      BR_JMP:  w_taken = 1'b1;
      BR_CALL: w_taken = 1'b1;
      BR_RET:  w_taken = !w_ras_empty;
      BR_RSVD: w_taken = 1'b0;
    endcase
  end

  assign w_tgt_pc = w_is_ret ? w_ras_top : w_target;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept && w_taken) w_state_nxt = HOLD;
      HOLD: if (redirect_ready)      w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z           <= 1'b0;
      r_n           <= 1'b0;
      r_redirect_pc <= '0;
      r_unf         <= 1'b0;
    end else begin
      if (alu_valid) begin
        r_z <= (alu_result == '0);
        r_n <= alu_result[DATA_W-1];
      end
      if (w_accept && w_taken) r_redirect_pc <= w_tgt_pc;
      r_unf <= w_accept && w_is_ret && w_ras_empty;
    end
  end

  assign redirect_valid = (r_state == HOLD);
  assign redirect_pc    = r_redirect_pc;
  assign ras_underflow  = r_unf;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit; CALL/RET expectations follow BRANCH_RAS_EN.
module tb_branch_unit;

  localparam int PC_W = 11;
  localparam int EV_REDIR = 0;
  localparam int EV_OVF   = 1;
  localparam int EV_UNF   = 2;

  localparam logic [2:0] C_BEQ  = 3'd0;
  localparam logic [2:0] C_BNE  = 3'd1;
  localparam logic [2:0] C_BLT  = 3'd2;
  localparam logic [2:0] C_BGE  = 3'd3;
  localparam logic [2:0] C_JMP  = 3'd4;
  localparam logic [2:0] C_CALL = 3'd5;
  localparam logic [2:0] C_RET  = 3'd6;
  localparam logic [2:0] C_RSVD = 3'd7;

  typedef struct {
    int             kind;
    logic [PC_W-1:0] pc;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc_in;
  logic            alu_valid;
  logic [15:0]     alu_result;
  logic            is_branch;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;
  logic            ras_overflow;
  logic            ras_underflow;

  ev_t  q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic r_prev_valid = 1'b0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_in          (pc_in),
    .alu_valid      (alu_valid),
    .alu_result     (alu_result),
    .is_branch      (is_branch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [PC_W-1:0] pc);
    ev_t e;
    e.kind = kind;
    e.pc   = pc;
    q.push_back(e);
  endtask

  task automatic seen_ev(input int kind, input logic [PC_W-1:0] pc);
    ev_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d pc %0h want none",
               kind, pc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == EV_REDIR && e.kind == EV_REDIR)
        chk("redirect_pc", 32'(pc), 32'(e.pc));
    end
  endtask

  // Monitor: a redirect is one rising edge of redirect_valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid && !r_prev_valid) seen_ev(EV_REDIR, redirect_pc);
      if (ras_overflow)  seen_ev(EV_OVF, '0);
      if (ras_underflow) seen_ev(EV_UNF, '0);
    end
    r_prev_valid <= redirect_valid;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic br(input logic [2:0] c, input logic [PC_W-1:0] t,
                    input logic [PC_W-1:0] pc, input logic av,
                    input logic [15:0] ar);
    wait_ready();
    instr       = {t, c, 2'b10};
    pc_in       = pc;
    instr_valid = 1'b1;
    alu_valid   = av;
    alu_result  = ar;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    alu_valid   = 1'b0;
  endtask

  task automatic alu(input logic [15:0] r);
    @(negedge clk);
    alu_valid  = 1'b1;
    alu_result = r;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    instr          = '0;
    instr_valid    = 1'b0;
    pc_in          = '0;
    alu_valid      = 1'b0;
    alu_result     = '0;
    redirect_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", 32'(redirect_pc), 0);
    chk("rst_ovf", 32'(ras_overflow), 0);
    chk("rst_unf", 32'(ras_underflow), 0);
    chk("rst_instr_ready", 32'(instr_ready), 1);

    instr = 16'h0001;
    #1 chk("is_branch_no", 32'(is_branch), 0);
    instr = 16'h0012;
    #1 chk("is_branch_yes", 32'(is_branch), 1);

    // BEQ taken after zero result, not taken after nonzero
    alu(16'h0000);
    push_ev(EV_REDIR, 11'h123);
    br(C_BEQ, 11'h123, 11'h001, 1'b0, '0);
    alu(16'h0005);
    br(C_BEQ, 11'h124, 11'h002, 1'b0, '0);

    // Same-cycle flag update: branch sees old Z=0
    br(C_BEQ, 11'h0AB, 11'h003, 1'b1, 16'h0000);
    push_ev(EV_REDIR, 11'h0AC);
    br(C_BEQ, 11'h0AC, 11'h004, 1'b0, '0);
    br(C_BNE, 11'h0AD, 11'h005, 1'b0, '0);

    // Negative result: Z=0, N=1
    alu(16'h8000);
    push_ev(EV_REDIR, 11'h0B1);
    br(C_BNE, 11'h0B1, 11'h006, 1'b0, '0);
    push_ev(EV_REDIR, 11'h0B2);
    br(C_BLT, 11'h0B2, 11'h007, 1'b0, '0);
    br(C_BGE, 11'h0B3, 11'h008, 1'b0, '0);
    br(C_RSVD, 11'h0B4, 11'h009, 1'b0, '0);

    // Non-branch carrying a JMP pattern is ignored
    wait_ready();
    instr       = {11'h0B5, C_JMP, 2'b11};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;

    // Handshake stall
    idle(2);
    redirect_ready = 1'b0;
    push_ev(EV_REDIR, 11'h040);
    br(C_JMP, 11'h040, 11'h00A, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(redirect_valid), 1);
      chk("stall_pc", 32'(redirect_pc), 32'h040);
      chk("stall_ready", 32'(instr_ready), 0);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(redirect_valid), 0);
    chk("release_ready", 32'(instr_ready), 1);

    // CALL / RET
    push_ev(EV_REDIR, 11'h200);
    br(C_CALL, 11'h200, 11'h010, 1'b0, '0);
`ifdef BRANCH_RAS_EN
    push_ev(EV_REDIR, 11'h011);
`else
    push_ev(EV_UNF, '0);
`endif
    br(C_RET, 11'h000, 11'h020, 1'b0, '0);
    push_ev(EV_UNF, '0);
    br(C_RET, 11'h000, 11'h021, 1'b0, '0);

    // Overflow: five calls into a four-entry stack
    for (int i = 1; i <= 5; i++) begin
      push_ev(EV_REDIR, 11'h300);
`ifdef BRANCH_RAS_EN
      if (i == 5) push_ev(EV_OVF, '0);
`endif
      br(C_CALL, 11'h300, 11'(i), 1'b0, '0);
    end
    for (int i = 0; i < 5; i++) begin
`ifdef BRANCH_RAS_EN
      if (i < 4) push_ev(EV_REDIR, 11'(6 - i));
      else       push_ev(EV_UNF, '0);
`else
      push_ev(EV_UNF, '0);
`endif
      br(C_RET, 11'h000, 11'h030, 1'b0, '0);
    end

    // Reset mid-HOLD
    idle(2);
    alu(16'h0000);
    redirect_ready = 1'b0;
    push_ev(EV_REDIR, 11'h055);
    br(C_CALL, 11'h055, 11'h007, 1'b0, '0);
    @(negedge clk);
    chk("hold_before_reset", 32'(redirect_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(redirect_valid), 0);
    chk("async_rst_pc", 32'(redirect_pc), 0);
    chk("async_rst_ready", 32'(instr_ready), 1);
    @(negedge clk);
    rst_n          = 1'b1;
    redirect_ready = 1'b1;
    br(C_BEQ, 11'h0AA, 11'h008, 1'b0, '0);
    push_ev(EV_UNF, '0);
    br(C_RET, 11'h000, 11'h009, 1'b0, '0);

    idle(5);
    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
